stk_cmd_arb: RTL and testbench

- Shares a single stack datapath between up to 8 engines.
- Accepts per-engine PUSH/POP commands, picks one per cycle with round-robin arbitration, tags it with the engine id and forwards it through a registered output stage.
- Routes pop responses back to the issuing engine.
- Caps outstanding POPs per engine with credit counters.
- Absorbs NOP and flags INV opcodes locally; neither reaches the stack.

---
 rtl/stk_cmd_arb_if.sv | 48 ++++
 rtl/stk_cmd_arb.sv | 145 ++++++++++++++
 tb/tb_stk_cmd_arb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stk_cmd_arb_if.sv
// Engine-side command/response and stack-side bundle for stk_cmd_arb.
// slave is the arbiter's view; master is the engines-plus-stack view.
interface stk_cmd_arb_if #(
  parameter int N_ENG  = 8,
  parameter int DATA_W = 32
);
  logic [N_ENG-1:0]        cmd_vld;
  logic [2*N_ENG-1:0]      cmd_opcode;
  logic [N_ENG*DATA_W-1:0] cmd_dat;
  logic [N_ENG-1:0]        cmd_rdy;
  logic                    stk_cmd_vld;
  logic [1:0]              stk_cmd_opcode;
  logic [2:0]              stk_cmd_engid;
  logic [DATA_W-1:0]       stk_cmd_dat;
  logic                    stk_cmd_rdy;
  logic                    stk_rsp_vld;
  logic [2:0]              stk_rsp_engid;
  logic [DATA_W-1:0]       stk_rsp_dat;
  logic [N_ENG-1:0]        rsp_vld;
  logic [DATA_W-1:0]       rsp_dat;
  logic [N_ENG-1:0]        inv_err;
  logic                    unexp_rsp;
  logic                    err_clr;

  modport slave (
    input  cmd_vld, cmd_opcode, cmd_dat,
    output cmd_rdy,
    output stk_cmd_vld, stk_cmd_opcode,
    output stk_cmd_engid, stk_cmd_dat,
    input  stk_cmd_rdy,
    input  stk_rsp_vld, stk_rsp_engid, stk_rsp_dat,
    output rsp_vld, rsp_dat,
    output inv_err, unexp_rsp,
    input  err_clr
  );

  modport master (
    output cmd_vld, cmd_opcode, cmd_dat,
    input  cmd_rdy,
    input  stk_cmd_vld, stk_cmd_opcode,
    input  stk_cmd_engid, stk_cmd_dat,
    output stk_cmd_rdy,
    output stk_rsp_vld, stk_rsp_engid, stk_rsp_dat,
    input  rsp_vld, rsp_dat,
    input  inv_err, unexp_rsp,
    output err_clr
  );
endinterface

// File: rtl/stk_cmd_arb.sv
// Round-robin arbiter sharing one stack among engines,
// with per-engine POP credits and response routing.
package stk_pkg;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_INV  = 2'b11
  } opcode_t;
  typedef logic [2:0] engid_t;
endpackage

module stk_cmd_arb #(
  parameter int N_ENG   = 8,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input logic          clk,
  input logic          arst_n,
  stk_cmd_arb_if.slave bus
);
  import stk_pkg::*;

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUT);

  opcode_t           w_op [N_ENG];
  engid_t            w_idx [N_ENG];
  logic [N_ENG-1:0]  w_local;
  logic [N_ENG-1:0]  w_inv;
  logic [N_ENG-1:0]  w_elig;
  logic [N_ENG-1:0]  w_gnt;
  logic [N_ENG-1:0]  w_inc;
  logic [N_ENG-1:0]  w_hit;
  logic              w_free;
  logic              w_gnt_vld;
  engid_t            w_gnt_id;
  opcode_t           w_gnt_op;
  logic [DATA_W-1:0] w_gnt_dat;
  logic              w_rsp_ok;
  logic              w_unexp;

  logic [CW-1:0]     r_cnt [N_ENG];
  engid_t            r_ptr;
  logic              r_vld;
  opcode_t           r_op;
  engid_t            r_eng;
  logic [DATA_W-1:0] r_dat;
  logic [N_ENG-1:0]  r_rsp_vld;
  logic [DATA_W-1:0] r_rsp_dat;
  logic [N_ENG-1:0]  r_inv;
  logic              r_unexp;

  always_comb begin
    for (int i = 0; i < N_ENG; i++) begin
      w_op[i]    = opcode_t'(bus.cmd_opcode[2*i +: 2]);
      w_local[i] = bus.cmd_vld[i] &
                   (w_op[i] == OP_NOP || w_op[i] == OP_INV);
      w_inv[i]   = bus.cmd_vld[i] & (w_op[i] == OP_INV);
      w_elig[i]  = bus.cmd_vld[i] &
                   (w_op[i] == OP_PUSH ||
                    (w_op[i] == OP_POP && r_cnt[i] < CMAX));
    end
  end

  assign w_free = ~r_vld | bus.stk_cmd_rdy;

  // Walk backwards so the candidate nearest the pointer wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = N_ENG - 1; k >= 0; k--) begin
      w_idx[k] = engid_t'((int'(r_ptr) + k) % N_ENG);
      if (w_free && w_elig[w_idx[k]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx[k];
      end
    end
  end

  always_comb begin
    w_gnt_op  = OP_NOP;
    w_gnt_dat = '0;
    for (int i = 0; i < N_ENG; i++) begin
      w_gnt[i] = w_gnt_vld && (int'(w_gnt_id) == i);
      w_inc[i] = w_gnt[i] && (w_op[i] == OP_POP);
      w_hit[i] = bus.stk_rsp_vld &&
                 (int'(bus.stk_rsp_engid) == i) &&
                 (r_cnt[i] != '0);
      if (w_gnt[i]) begin
        w_gnt_op  = w_op[i];
        w_gnt_dat = (w_op[i] == OP_PUSH) ?
                    bus.cmd_dat[i*DATA_W +: DATA_W] : '0;
      end
    end
  end

  assign w_rsp_ok = |w_hit;
  assign w_unexp  = bus.stk_rsp_vld & ~w_rsp_ok;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ptr     <= '0;
      r_vld     <= 1'b0;
      r_op      <= OP_NOP;
      r_eng     <= '0;
      r_dat     <= '0;
      r_rsp_vld <= '0;
      r_rsp_dat <= '0;
      r_inv     <= '0;
      r_unexp   <= 1'b0;
      for (int i = 0; i < N_ENG; i++) r_cnt[i] <= '0;
    end else begin
      if (w_free) r_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_ptr <= (int'(w_gnt_id) == N_ENG - 1) ?
                 '0 : w_gnt_id + 3'd1;
        r_op  <= w_gnt_op;
        r_eng <= w_gnt_id;
        r_dat <= w_gnt_dat;
      end
      for (int i = 0; i < N_ENG; i++) begin
        if (w_inc[i] && !w_hit[i])
          r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (!w_inc[i] && w_hit[i])
          r_cnt[i] <= r_cnt[i] - CW'(1);
      end
      r_rsp_vld <= w_hit;
      if (w_rsp_ok) r_rsp_dat <= bus.stk_rsp_dat;
      r_inv   <= w_inv | (r_inv & ~{N_ENG{bus.err_clr}});
      r_unexp <= w_unexp | (r_unexp & ~bus.err_clr);
    end
  end

  assign bus.cmd_rdy = {N_ENG{arst_n}} & (w_local | w_gnt);

  assign bus.stk_cmd_vld    = r_vld;
  assign bus.stk_cmd_opcode = r_op;
  assign bus.stk_cmd_engid  = r_eng;
  assign bus.stk_cmd_dat    = r_dat;
  assign bus.rsp_vld        = r_rsp_vld;
  assign bus.rsp_dat        = r_rsp_dat;
  assign bus.inv_err        = r_inv;
  assign bus.unexp_rsp      = r_unexp;
endmodule

// File: tb/tb_stk_cmd_arb.sv
// Directed bench for stk_cmd_arb: vector table for arbitration
// order, hand sequences for stall, credits, errors and reset.
module tb_stk_cmd_arb;
  logic clk;
  logic arst_n;
  int   n_chk;
  int   n_fail;

  stk_cmd_arb_if #(.N_ENG(8), .DATA_W(32)) bus ();

  stk_cmd_arb #(
    .N_ENG(8), .DATA_W(32), .MAX_OUT(4)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  vld;
    logic [15:0] op;
    logic        srdy;
    logic [7:0]  rdy;
    logic        svld;
    logic [2:0]  eng;
  } vec_t;

  vec_t tbl [14];

  function automatic void chk(string nm, logic [63:0] a,
                              logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [7:0] v, logic [15:0] op);
    bus.cmd_vld    = v;
    bus.cmd_opcode = op;
  endtask

  task automatic rsp(logic v, logic [2:0] e, logic [31:0] d);
    bus.stk_rsp_vld   = v;
    bus.stk_rsp_engid = e;
    bus.stk_rsp_dat   = d;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    tbl[0]  = '{8'hFF, 16'h5555, 1'b1, 8'h01, 1'b0, 3'd0};
    tbl[1]  = '{8'hFF, 16'h5555, 1'b1, 8'h02, 1'b1, 3'd0};
    tbl[2]  = '{8'hFF, 16'h5555, 1'b1, 8'h04, 1'b1, 3'd1};
    tbl[3]  = '{8'hFF, 16'h5555, 1'b1, 8'h08, 1'b1, 3'd2};
    tbl[4]  = '{8'hFF, 16'h5555, 1'b1, 8'h10, 1'b1, 3'd3};
    tbl[5]  = '{8'hFF, 16'h5555, 1'b1, 8'h20, 1'b1, 3'd4};
    tbl[6]  = '{8'hFF, 16'h5555, 1'b1, 8'h40, 1'b1, 3'd5};
    tbl[7]  = '{8'hFF, 16'h5555, 1'b1, 8'h80, 1'b1, 3'd6};
    tbl[8]  = '{8'hFF, 16'h5555, 1'b1, 8'h01, 1'b1, 3'd7};
    tbl[9]  = '{8'h00, 16'h5555, 1'b1, 8'h00, 1'b1, 3'd0};
    tbl[10] = '{8'h00, 16'h5555, 1'b1, 8'h00, 1'b0, 3'd0};
    tbl[11] = '{8'h61, 16'h1C00, 1'b1, 8'h61, 1'b0, 3'd0};
    tbl[12] = '{8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 3'd6};
    tbl[13] = '{8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 3'd0};

    arst_n = 1'b0;
    bus.err_clr = 1'b0;
    bus.stk_cmd_rdy = 1'b1;
    rsp(1'b0, 3'd0, 32'h0);
    for (int i = 0; i < 8; i++)
      bus.cmd_dat[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
    drv(8'hFF, 16'h5555);
    cyc();
    cyc();
    #1;
    chk("rst cmd_rdy", 64'(bus.cmd_rdy), 64'h0);
    chk("rst stk_vld", 64'(bus.stk_cmd_vld), 64'h0);
    chk("rst stk_op", 64'(bus.stk_cmd_opcode), 64'h0);
    chk("rst stk_eng", 64'(bus.stk_cmd_engid), 64'h0);
    chk("rst stk_dat", 64'(bus.stk_cmd_dat), 64'h0);
    chk("rst rsp_vld", 64'(bus.rsp_vld), 64'h0);
    chk("rst rsp_dat", 64'(bus.rsp_dat), 64'h0);
    chk("rst inv_err", 64'(bus.inv_err), 64'h0);
    chk("rst unexp", 64'(bus.unexp_rsp), 64'h0);
    cyc();
    arst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      drv(tbl[r].vld, tbl[r].op);
      bus.stk_cmd_rdy = tbl[r].srdy;
      #1;
      chk($sformatf("vec%0d cmd_rdy", r),
          64'(bus.cmd_rdy), 64'(tbl[r].rdy));
      chk($sformatf("vec%0d stk_vld", r),
          64'(bus.stk_cmd_vld), 64'(tbl[r].svld));
      if (tbl[r].svld)
        chk($sformatf("vec%0d stk_eng", r),
            64'(bus.stk_cmd_engid), 64'(tbl[r].eng));
      cyc();
    end

    #1;
    chk("local inv_err", 64'(bus.inv_err), 64'h20);
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    #1;
    chk("clr inv_err", 64'(bus.inv_err), 64'h0);
    cyc();

    bus.stk_cmd_rdy = 1'b0;
    drv(8'h08, 16'h0040);
    #1;
    chk("bp grant", 64'(bus.cmd_rdy), 64'h08);
    cyc();
    bus.cmd_dat[3*32 +: 32] = 32'hA5A5_0033;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d vld", k), 64'(bus.stk_cmd_vld), 64'h1);
      chk($sformatf("bp%0d eng", k), 64'(bus.stk_cmd_engid), 64'h3);
      chk($sformatf("bp%0d op", k), 64'(bus.stk_cmd_opcode), 64'h1);
      chk($sformatf("bp%0d dat", k), 64'(bus.stk_cmd_dat),
          64'hA5A5_0003);
      chk($sformatf("bp%0d rdy", k), 64'(bus.cmd_rdy), 64'h0);
      cyc();
    end
    bus.stk_cmd_rdy = 1'b1;
    #1;
    chk("bp release rdy", 64'(bus.cmd_rdy), 64'h08);
    cyc();
    drv(8'h00, 16'h0000);
    #1;
    chk("bp next dat", 64'(bus.stk_cmd_dat), 64'hA5A5_0033);
    cyc();

    drv(8'h04, 16'h0020);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("pop2 #%0d rdy", k), 64'(bus.cmd_rdy), 64'h04);
      cyc();
    end
    #1;
    chk("pop2 op", 64'(bus.stk_cmd_opcode), 64'h2);
    chk("pop2 dat", 64'(bus.stk_cmd_dat), 64'h0);
    chk("pop2 eng", 64'(bus.stk_cmd_engid), 64'h2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pop2 cap%0d", k), 64'(bus.cmd_rdy), 64'h0);
      cyc();
      #1;
    end
    rsp(1'b1, 3'd2, 32'hDEAD_0002);
    chk("pop2 rsp cycle rdy", 64'(bus.cmd_rdy), 64'h0);
    cyc();
    rsp(1'b0, 3'd0, 32'h0);
    #1;
    chk("pop2 rsp_vld", 64'(bus.rsp_vld), 64'h04);
    chk("pop2 rsp_dat", 64'(bus.rsp_dat), 64'hDEAD_0002);
    chk("pop2 5th rdy", 64'(bus.cmd_rdy), 64'h04);
    cyc();
    #1;
    chk("pop2 rsp pulse", 64'(bus.rsp_vld), 64'h0);
    chk("pop2 full again", 64'(bus.cmd_rdy), 64'h0);
    cyc();

    drv(8'h02, 16'h0008);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("pop1 #%0d rdy", k), 64'(bus.cmd_rdy), 64'h02);
      cyc();
    end
    rsp(1'b1, 3'd1, 32'hDEAD_0001);
    #1;
    chk("same cyc no grant", 64'(bus.cmd_rdy), 64'h0);
    cyc();
    rsp(1'b0, 3'd0, 32'h0);
    #1;
    chk("same cyc next rdy", 64'(bus.cmd_rdy), 64'h02);
    chk("same cyc rsp_vld", 64'(bus.rsp_vld), 64'h02);
    cyc();
    #1;
    chk("same cyc full", 64'(bus.cmd_rdy), 64'h0);
    cyc();
    drv(8'h00, 16'h0000);

    rsp(1'b1, 3'd4, 32'hDEAD_0004);
    cyc();
    rsp(1'b0, 3'd0, 32'h0);
    #1;
    chk("unexp rsp_vld", 64'(bus.rsp_vld), 64'h0);
    chk("unexp flag", 64'(bus.unexp_rsp), 64'h1);
    cyc();
    rsp(1'b1, 3'd4, 32'hDEAD_0004);
    bus.err_clr = 1'b1;
    cyc();
    rsp(1'b0, 3'd0, 32'h0);
    bus.err_clr = 1'b0;
    #1;
    chk("set wins clr", 64'(bus.unexp_rsp), 64'h1);
    cyc();
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    #1;
    chk("unexp cleared", 64'(bus.unexp_rsp), 64'h0);
    cyc();

    drv(8'h80, 16'hC000);
    rsp(1'b1, 3'd5, 32'hDEAD_0005);
    #1;
    chk("inv7 rdy", 64'(bus.cmd_rdy), 64'h80);
    cyc();
    rsp(1'b0, 3'd0, 32'h0);
    drv(8'h01, 16'h0001);
    cyc();
    #1;
    chk("pre rst vld", 64'(bus.stk_cmd_vld), 64'h1);
    chk("pre rst inv", 64'(bus.inv_err), 64'h80);
    chk("pre rst unexp", 64'(bus.unexp_rsp), 64'h1);
    #1;
    arst_n = 1'b0;
    #1;
    chk("mid rst cmd_rdy", 64'(bus.cmd_rdy), 64'h0);
    chk("mid rst stk_vld", 64'(bus.stk_cmd_vld), 64'h0);
    chk("mid rst stk_op", 64'(bus.stk_cmd_opcode), 64'h0);
    chk("mid rst stk_dat", 64'(bus.stk_cmd_dat), 64'h0);
    chk("mid rst rsp_dat", 64'(bus.rsp_dat), 64'h0);
    chk("mid rst inv", 64'(bus.inv_err), 64'h0);
    chk("mid rst unexp", 64'(bus.unexp_rsp), 64'h0);
    cyc();
    arst_n = 1'b1;
    drv(8'h00, 16'h0000);
    rsp(1'b1, 3'd2, 32'hDEAD_0222);
    cyc();
    rsp(1'b0, 3'd0, 32'h0);
    #1;
    chk("post rst rsp_vld", 64'(bus.rsp_vld), 64'h0);
    chk("post rst unexp", 64'(bus.unexp_rsp), 64'h1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
